// File: rtl/sar_search.sv
// Successive-approximation search for a signed target seen only through an external less-than comparator.
// One bit resolved per accepted response (N responses), done pulses one cycle after the last; cand holds across stalls.
module sar_search #(
   parameter int N = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic signed [N-1:0] cand,
   output logic                cand_valid,
   input  logic                cmp_valid,
   input  logic                cmp_lt,
   output logic                busy,
   output logic                done,
   output logic signed [N-1:0] result
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  trial_q, trial_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [N-1:0]  result_q, result_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         trial_q  <= '0;
         idx_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         trial_q  <= trial_d;
         idx_q    <= idx_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      trial_d  = trial_q;
      idx_d    = idx_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = PROBE;
               trial_d = {1'b1, {(N-1){1'b0}}};
               idx_d   = IW'(N-1);
            end
         end
         PROBE: begin
            if (cmp_valid) begin
               if (cmp_lt) trial_d[idx_q] = 1'b0;
               if (idx_q != '0) begin
                  trial_d[idx_q - 1'b1] = 1'b1;
                  idx_d                 = idx_q - 1'b1;
               end else begin
                  // trial is offset-binary; flip the MSB to get two's complement
                  result_d = {~trial_d[N-1], trial_d[N-2:0]};
                  state_d  = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode registered state only, so comparator inputs never reach them combinationally.
   assign cand       = {~trial_q[N-1], trial_q[N-2:0]};
   assign cand_valid = (state_q == PROBE);
   assign busy       = (state_q == PROBE);
   assign done       = (state_q == DONE);
   assign result     = result_q;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: an N=8 instance for the detailed scenarios and an N=32 instance for a random sweep.
module tb_sar_search;

   logic clk = 1'b0;
   logic rst;

   logic              start8, cmp_valid8, cmp_lt8, cand_valid8, busy8, done8;
   logic signed [7:0] cand8, result8, target8;

   logic               start32, cmp_valid32, cmp_lt32, cand_valid32, busy32, done32;
   logic signed [31:0] cand32, result32, target32;

   int checks   = 0;
   int failures = 0;

   logic signed [7:0] obs_seq [8];
   logic signed [7:0] seq_p5  [8] = '{8'sd0, 8'sd64, 8'sd32, 8'sd16, 8'sd8, 8'sd4, 8'sd6, 8'sd5};
   logic signed [7:0] seq_m128[8] = '{8'sd0, -8'sd64, -8'sd96, -8'sd112, -8'sd120, -8'sd124, -8'sd126, -8'sd127};

   always #5 clk = ~clk;

   // Comparator model: 1 when target is strictly below the candidate, signed.
   assign cmp_lt8  = (target8 < cand8);
   assign cmp_lt32 = (target32 < cand32);

   sar_search #(.N(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .cand(cand8), .cand_valid(cand_valid8),
      .cmp_valid(cmp_valid8), .cmp_lt(cmp_lt8), .busy(busy8), .done(done8), .result(result8)
   );

   sar_search #(.N(32)) dut32 (
      .clk(clk), .rst(rst), .start(start32), .cand(cand32), .cand_valid(cand_valid32),
      .cmp_valid(cmp_valid32), .cmp_lt(cmp_lt32), .busy(busy32), .done(done32), .result(result32)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic search8(input int tgt, input int maxgap, input bit pulse, input int prev_res);
      int g;
      target8 = tgt[7:0];
      start8  = 1'b1;
      step();
      start8  = 1'b0;
      chk("first_cand_valid", cand_valid8, 1);
      for (int i = 0; i < 8; i++) begin
         obs_seq[i] = cand8;
         chk("probe_busy", busy8, 1);
         chk("probe_no_done", done8, 0);
         chk("result_held", result8, prev_res);
         g          = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
         cmp_valid8 = 1'b0;
         start8     = pulse && (i == 3);
         repeat (g) begin
            step();
            chk("stall_cand", cand8, obs_seq[i]);
            chk("stall_cand_valid", cand_valid8, 1);
         end
         cmp_valid8 = 1'b1;
         step();
      end
      // cmp_valid stays high and start may pulse during the DONE cycle; both must be ignored
      start8 = pulse;
      chk("done_pulse", done8, 1);
      chk("busy_with_done", busy8, 0);
      chk("cand_valid_in_done", cand_valid8, 0);
      chk("result", result8, tgt);
      step();
      start8     = 1'b0;
      cmp_valid8 = 1'b0;
      chk("done_one_cycle", done8, 0);
      chk("idle_busy", busy8, 0);
      chk("idle_cand_valid", cand_valid8, 0);
      chk("result_after_idle", result8, tgt);
   endtask

   task automatic search32(input int tgt);
      target32    = tgt;
      start32     = 1'b1;
      step();
      start32     = 1'b0;
      cmp_valid32 = 1'b1;
      for (int i = 0; i < 32; i++) begin
         chk("probe32_busy_done", {busy32, done32}, 2);
         step();
      end
      chk("done32_busy_done", {busy32, done32}, 1);
      chk("result32", result32, tgt);
      cmp_valid32 = 1'b0;
      step();
   endtask

   initial begin
      rst         = 1'b1;
      start8      = 1'b0;
      cmp_valid8  = 1'b0;
      target8     = '0;
      start32     = 1'b0;
      cmp_valid32 = 1'b0;
      target32    = '0;
      step();
      step();
      chk("rst_busy8", busy8, 0);
      chk("rst_done8", done8, 0);
      chk("rst_cand_valid8", cand_valid8, 0);
      chk("rst_result8", result8, 0);
      chk("rst_busy32", busy32, 0);
      chk("rst_result32", result32, 0);
      rst = 1'b0;
      step();

      search8(5, 0, 1'b0, 0);
      for (int i = 0; i < 8; i++) chk("seq_t5", obs_seq[i], seq_p5[i]);
      search8(-128, 0, 1'b0, 5);
      for (int i = 0; i < 8; i++) chk("seq_tm128", obs_seq[i], seq_m128[i]);
      search8(127, 0, 1'b0, -128);
      search8(-1, 0, 1'b0, 127);
      search8(0, 0, 1'b0, -1);
      search8(-37, 5, 1'b0, 0);
      search8(20, 0, 1'b1, -37);
      search8(-90, 0, 1'b0, 20);

      // Abort mid-search with reset
      target8 = 8'sd77;
      start8  = 1'b1;
      step();
      start8     = 1'b0;
      cmp_valid8 = 1'b1;
      repeat (3) step();
      cmp_valid8 = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", busy8, 0);
      chk("abort_cand_valid", cand_valid8, 0);
      chk("abort_done", done8, 0);
      chk("abort_result", result8, 0);
      repeat (2) begin
         step();
         chk("abort_no_done", done8, 0);
      end
      rst = 1'b0;
      step();
      search8(100, 0, 1'b0, 0);

      search32(int'(32'h8000_0000));
      search32(int'(32'h7fff_ffff));
      for (int i = 0; i < 1000; i++) search32(int'($urandom()));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter: N, default 32, data width of candidate and result, two's complement signed; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request a new search; sampled only in IDLE.
REQ-005 cand  output  N  signed candidate value presented to the external signed less-than comparator.
REQ-006 cand_valid  output  1  cand is valid and awaiting a comparison response.
REQ-007 cmp_valid  input  1  comparison response valid this cycle.
REQ-008 cmp_lt  input  1  response: 1 means target < cand (signed); qualified by cmp_valid.
REQ-009 busy  output  1  search in progress (state PROBE).
REQ-010 done  output  1  one-cycle pulse: search complete, result updated.
REQ-011 result  output  N  signed search result; held until the next accepted start.

Function
REQ-012 Purpose: find the signed target known only through an external comparator, by successive approximation; result is the exact target for every value in [-2^(N-1), 2^(N-1)-1].
REQ-013 Internal state: trial (N bits, offset-binary), idx (ceil(log2 N) bits), FSM state in {IDLE, PROBE, DONE}.
REQ-014 Mapping: cand = trial with MSB inverted (offset-binary to two's complement); result uses the same mapping.
REQ-015 IDLE: cand_valid=0, busy=0, done=0; on start=1, go to PROBE with trial=1 followed by N-1 zeros (cand=0) and idx=N-1.
REQ-016 PROBE: cand_valid=1, busy=1; cand and trial stay constant until a cycle with cmp_valid=1.
REQ-017 PROBE, cmp_valid=1: if cmp_lt=1, clear trial[idx]; if idx>0, also set trial[idx-1] and decrement idx; stay in PROBE.
REQ-018 PROBE, cmp_valid=1 and idx=0: apply the bit-0 decision, write result from the final trial, go to DONE.
REQ-019 DONE: done=1, cand_valid=0, busy=0 for exactly one cycle; then go unconditionally to IDLE.
REQ-020 start is ignored in PROBE and DONE; no queuing. cmp_valid is ignored in IDLE and DONE.
REQ-021 Exactly N accepted responses per search; no early termination.
REQ-022 Latency with cmp_valid held at 1: start sampled at edge k; cand_valid high for cycles k+1..k+N; done high in cycle k+N+1; busy is never high in the same cycle as done.
REQ-023 Responses may arrive any number of cycles after cand_valid rises, including in the same cycle; a stall of any length shall not alter cand.
REQ-024 cand is driven from the registered trial only, with no combinational path from cmp_valid or cmp_lt to any output.
REQ-025 result is not modified by an aborted search (reset excepted) or by an ignored start.

Reset
REQ-026 While rst=1: state=IDLE, trial=0, idx=0, result=0, done=0, busy=0, cand_valid=0, asynchronously.
REQ-027 rst asserted mid-PROBE abandons the search with no done pulse; the first start after rst deasserts begins a fresh search per REQ-015.

Verification
REQ-028 The bench models the comparator as cmp_lt = (target < cand) signed, and checks every probe against this model.
REQ-029 N=8, target=5, cmp_valid=1: cand sequence 0,64,32,16,8,4,6,5; done at cycle k+9; result=5.
REQ-030 N=8, targets -128, 127, -1, 0: results match the targets; -128 gives cand sequence 0,-64,-96,-112,-120,-124,-126,-127.
REQ-031 N=8, target=-37, cmp_valid with random 0-5 cycle gaps: cand stable across every stall; exactly 8 responses consumed; result=-37.
REQ-032 N=8, start pulsed during PROBE and in the DONE cycle: search unaffected; done pulses exactly once; next start in IDLE is accepted.
REQ-033 N=8, rst asserted after 3 responses: outputs zero immediately, with no done pulse; then target=100 gives result=100.
REQ-034 N=32, 1000 random targets plus -2^31 and 2^31-1: every result equals its target; busy/done never both high.
